// File: rtl/shared_ram_if.sv
// Per-CPU request/response bundle for the shared RAM arbiter.
// The CPU side drives the request and the arbiter drives the response.
interface shared_ram_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          REQ;
  logic          WE;
  logic [AW-1:0] ADRS;
  logic [DW-1:0] DO;
  logic [DW-1:0] DI;
  logic          ACK;
  logic          GNT;

  modport master (output REQ, WE, ADRS, DO, input DI, ACK, GNT);
  modport slave  (input REQ, WE, ADRS, DO, output DI, ACK, GNT);
endinterface

// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// main and sub CPUs, with registered RAM controls and per-side read data.
module shared_ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  shared_ram_if.slave   M,
  shared_ram_if.slave   S,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_WD,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_RD,
  output logic          BUSY
);

  typedef enum logic [1:0] {IDLE, ACC, DATA, DONE} state_t;

  localparam logic SIDE_MAIN = 1'b0;
  localparam logic SIDE_SUB  = 1'b1;

  state_t        state;
  logic          owner;
  logic          last;
  logic          wr;
  logic          pick_sub;
  logic [DW-1:0] m_di, s_di;
  logic          m_ack, s_ack, m_gnt, s_gnt;

  // Sub wins when it is alone, or on a tie when main was served last.
  always_comb begin
    pick_sub = S.REQ && (!M.REQ || (last == SIDE_MAIN));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      owner  <= SIDE_MAIN;
      last   <= SIDE_SUB;
      wr     <= 1'b0;
      RAM_A  <= '0;
      RAM_WD <= '0;
      RAM_WE <= 1'b0;
      m_di   <= '0;
      s_di   <= '0;
      m_ack  <= 1'b0;
      s_ack  <= 1'b0;
      m_gnt  <= 1'b0;
      s_gnt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (M.REQ || S.REQ) begin
            owner  <= pick_sub;
            wr     <= pick_sub ? S.WE   : M.WE;
            RAM_A  <= pick_sub ? S.ADRS : M.ADRS;
            RAM_WD <= pick_sub ? S.DO   : M.DO;
            RAM_WE <= pick_sub ? S.WE   : M.WE;
            m_gnt  <= !pick_sub;
            s_gnt  <= pick_sub;
            state  <= ACC;
          end
        end
        // Address on the RAM this cycle; write strobe lasts only here.
        ACC: begin
          RAM_WE <= 1'b0;
          state  <= DATA;
        end
        // RAM_RD now reflects RAM_A.
        DATA: begin
          if (!wr) begin
            if (owner == SIDE_SUB) s_di <= RAM_RD;
            else                   m_di <= RAM_RD;
          end
          m_ack <= (owner == SIDE_MAIN);
          s_ack <= (owner == SIDE_SUB);
          state <= DONE;
        end
        DONE: begin
          m_ack <= 1'b0;
          s_ack <= 1'b0;
          m_gnt <= 1'b0;
          s_gnt <= 1'b0;
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign M.DI  = m_di;
  assign S.DI  = s_di;
  assign M.ACK = m_ack;
  assign S.ACK = s_ack;
  assign M.GNT = m_gnt;
  assign S.GNT = s_gnt;
  assign BUSY  = (state != IDLE);

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench for shared_ram_arbiter: a RAM model plus a scoreboard of
// expected completions popped on every ACK.
module tb_shared_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          CLK;
  logic          RESET_N;
  logic [AW-1:0] RAM_A;
  logic [DW-1:0] RAM_WD;
  logic          RAM_WE;
  logic [DW-1:0] RAM_RD;
  logic          BUSY;

  shared_ram_if #(.AW(AW), .DW(DW)) m_if ();
  shared_ram_if #(.AW(AW), .DW(DW)) s_if ();

  shared_ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .M       (m_if),
    .S       (s_if),
    .RAM_A   (RAM_A),
    .RAM_WD  (RAM_WD),
    .RAM_WE  (RAM_WE),
    .RAM_RD  (RAM_RD),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous single-port RAM: read data one cycle after the address.
  logic [DW-1:0] mem [1024];
  logic          mem_clr;
  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (RAM_WE) begin
      mem[RAM_A] <= RAM_WD;
    end
    RAM_RD <= mem[RAM_A];
  end

  typedef struct {
    bit            side;
    bit            we;
    logic [AW-1:0] adrs;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [1024];
  int            nchk = 0;
  int            nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input bit side, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.side = side;
    e.we   = we;
    e.adrs = a;
    if (we) model[a] = d;
    e.data = model[a];
    sb.push_back(e);
  endtask

  // Completion monitor: write strobe accounting, protocol invariants, scoreboard.
  int            we_cnt = 0;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  always @(negedge CLK) begin
    if (!RESET_N) begin
      we_cnt = 0;
    end else begin
      check("gnt_overlap", {31'd0, m_if.GNT & s_if.GNT}, 0);
      check("ack_overlap", {31'd0, m_if.ACK & s_if.ACK}, 0);
      check("we_outside_access", {31'd0, RAM_WE & ~BUSY}, 0);
      if (RAM_WE) begin
        we_cnt++;
        wa = RAM_A;
        wd = RAM_WD;
      end
      if (m_if.ACK || s_if.ACK) begin
        check("sb_nonempty", {31'd0, sb.size() > 0}, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("ack_side", {31'd0, s_if.ACK}, {31'd0, e.side});
          check("ram_a", {22'd0, RAM_A}, {22'd0, e.adrs});
          check("we_cycles", we_cnt, e.we ? 1 : 0);
          if (e.we) begin
            check("wr_addr", {22'd0, wa}, {22'd0, e.adrs});
            check("wr_data", {24'd0, wd}, {24'd0, e.data});
          end else begin
            check("rd_data", {24'd0, s_if.ACK ? s_if.DI : m_if.DI}, {24'd0, e.data});
          end
        end
        we_cnt = 0;
      end
    end
  end

  task automatic idle_reqs();
    m_if.REQ = 0; m_if.WE = 0; m_if.ADRS = '0; m_if.DO = '0;
    s_if.REQ = 0; s_if.WE = 0; s_if.ADRS = '0; s_if.DO = '0;
  endtask

  task automatic do_reset();
    RESET_N = 0;
    idle_reqs();
    repeat (3) tick();
    RESET_N = 1;
    tick();
  endtask

  task automatic issue(input bit m_en, input bit m_we, input logic [AW-1:0] m_a, input logic [DW-1:0] m_d,
                       input bit s_en, input bit s_we, input logic [AW-1:0] s_a, input logic [DW-1:0] s_d,
                       input bit chg, input logic [AW-1:0] chg_a,
                       output int m_lat, output int s_lat);
    bit m_done;
    bit s_done;
    int t;
    m_done = !m_en;
    s_done = !s_en;
    t = 0;
    m_lat = 0;
    s_lat = 0;
    m_if.REQ = m_en; m_if.WE = m_we; m_if.ADRS = m_a; m_if.DO = m_d;
    s_if.REQ = s_en; s_if.WE = s_we; s_if.ADRS = s_a; s_if.DO = s_d;
    while (!(m_done && s_done) && t < 40) begin
      tick();
      t++;
      if (chg && t == 1) m_if.ADRS = chg_a;
      if (!m_done && m_if.ACK) begin m_if.REQ = 0; m_done = 1; m_lat = t; end
      if (!s_done && s_if.ACK) begin s_if.REQ = 0; s_done = 1; s_lat = t; end
    end
    check("issue_timeout", {31'd0, m_done && s_done}, 1);
    tick();
  endtask

  int ml, sl;

  initial begin
    RESET_N = 0;
    mem_clr = 1;
    idle_reqs();
    for (int i = 0; i < 1024; i++) model[i] = '0;
    repeat (3) tick();
    mem_clr = 0;

    // Reset state
    check("rst_busy", {31'd0, BUSY}, 0);
    check("rst_ram_we", {31'd0, RAM_WE}, 0);
    check("rst_ram_a", {22'd0, RAM_A}, 0);
    check("rst_ram_wd", {24'd0, RAM_WD}, 0);
    check("rst_gnt", {30'd0, m_if.GNT, s_if.GNT}, 0);
    check("rst_ack", {30'd0, m_if.ACK, s_if.ACK}, 0);
    check("rst_di", {16'd0, m_if.DI, s_if.DI}, 0);
    RESET_N = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_busy", {31'd0, BUSY}, 0);
      check("idle_ram_we", {31'd0, RAM_WE}, 0);
    end

    // Main write then read
    push(0, 1, 10'h155, 8'hA5);
    issue(1, 1, 10'h155, 8'hA5, 0, 0, '0, '0, 0, '0, ml, sl);
    check("mw_latency", ml, 3);
    push(0, 0, 10'h155, 8'h00);
    issue(1, 0, 10'h155, 8'h00, 0, 0, '0, '0, 0, '0, ml, sl);
    check("mr_latency", ml, 3);
    check("m_di_hold", {24'd0, m_if.DI}, 32'hA5);
    check("s_di_untouched", {24'd0, s_if.DI}, 0);
    check("busy_after", {31'd0, BUSY}, 0);

    // Simultaneous requests just after reset: main first
    do_reset();
    push(0, 0, 10'h000, 8'h00);
    push(1, 1, 10'h3FF, 8'h5A);
    issue(1, 0, 10'h000, 8'h00, 1, 1, 10'h3FF, 8'h5A, 0, '0, ml, sl);
    check("sim_m_latency", ml, 3);
    check("sim_ack_gap", sl - ml, 4);

    // Continuous contention: alternation M,S,M,S,...
    begin
      int  m_srv, s_srv, t;
      bit  m_rr, s_rr;
      m_srv = 0; s_srv = 0; t = 0; m_rr = 0; s_rr = 0;
      for (int i = 0; i < 4; i++) begin
        push(0, 0, 10'h155, 8'h00);
        push(1, 0, 10'h3FF, 8'h00);
      end
      m_if.REQ = 1; m_if.WE = 0; m_if.ADRS = 10'h155;
      s_if.REQ = 1; s_if.WE = 0; s_if.ADRS = 10'h3FF;
      while (!(m_srv == 4 && s_srv == 4) && t < 100) begin
        tick();
        t++;
        if (m_rr) begin m_if.REQ = (m_srv < 4); m_rr = 0; end
        if (s_rr) begin s_if.REQ = (s_srv < 4); s_rr = 0; end
        if (m_if.ACK) begin m_if.REQ = 0; m_srv++; m_rr = 1; end
        if (s_if.ACK) begin s_if.REQ = 0; s_srv++; s_rr = 1; end
      end
      check("contention_done", {31'd0, m_srv == 4 && s_srv == 4}, 1);
      idle_reqs();
      tick();
    end

    // Address change while granted is ignored
    push(0, 1, 10'h010, 8'h3C);
    issue(1, 1, 10'h010, 8'h3C, 0, 0, '0, '0, 0, '0, ml, sl);
    push(0, 1, 10'h020, 8'hC3);
    issue(1, 1, 10'h020, 8'hC3, 0, 0, '0, '0, 0, '0, ml, sl);
    push(0, 0, 10'h010, 8'h00);
    issue(1, 0, 10'h010, 8'h00, 0, 0, '0, '0, 1, 10'h020, ml, sl);
    check("chg_m_di", {24'd0, m_if.DI}, 32'h3C);

    // Reset during a sub write
    s_if.REQ = 1; s_if.WE = 1; s_if.ADRS = 10'h100; s_if.DO = 8'h77;
    tick();
    check("abort_we_in_acc", {31'd0, RAM_WE}, 1);
    check("abort_s_gnt", {31'd0, s_if.GNT}, 1);
    RESET_N = 0;
    #1;
    check("abort_we_drop", {31'd0, RAM_WE}, 0);
    check("abort_busy", {31'd0, BUSY}, 0);
    check("abort_no_ack", {31'd0, s_if.ACK}, 0);
    check("abort_gnt_clr", {31'd0, s_if.GNT}, 0);
    idle_reqs();
    repeat (2) tick();
    RESET_N = 1;
    tick();
    check("abort_idle_ack", {30'd0, m_if.ACK, s_if.ACK}, 0);
    push(0, 0, 10'h100, 8'h00);
    push(1, 0, 10'h020, 8'h00);
    issue(1, 0, 10'h100, 8'h00, 1, 0, 10'h020, 8'h00, 0, '0, ml, sl);
    check("post_rst_m_first", {31'd0, ml < sl}, 1);
    check("post_rst_m_di", {24'd0, m_if.DI}, 0);
    check("post_rst_s_di", {24'd0, s_if.DI}, 32'hC3);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
